// File: rtl/alu_cmd_issuer.sv
// Initiator front end for the registered ALU: queues commands, issues one at a time,
// waits out the ALU latency and returns each captured result on a valid/ready stream.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [2:0] rsp_op,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [1:0]    r_state;
  logic [2:0]    r_wait;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [2:0]    r_alu_op;
  logic          r_rsp_valid;
  logic [3:0]    r_rsp_result;
  logic          r_rsp_carry;
  logic          r_rsp_zero;
  logic [2:0]    r_rsp_op;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_arith;
  cmd_t          w_head;

  // cmd_ready depends only on the registered count, so a pop on a full edge cannot admit a push.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_arith = (r_alu_op[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_alu_a  <= w_head.a;
            r_alu_b  <= w_head.b;
            r_alu_op <= w_head.op;
            r_wait   <= 3'(LAT);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter hits zero LAT+1 edges after issue, once the ALU register has settled.
          if (r_wait == 3'd0) begin
            r_rsp_result <= alu_result;
            r_rsp_carry  <= alu_carry && w_arith;
            r_rsp_zero   <= (alu_result == 4'd0);
            r_rsp_op     <= r_alu_op;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_op     = r_rsp_op;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU stand-in, arithmetic reference model and
// per-scenario tasks comparing accepted commands against returned responses in order.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int NRAND = 2 * DEPTH + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [2:0] rsp_op;
  logic       busy;

  logic       force_carry = 1'b0;
  logic [3:0] m_res;
  logic       m_carry;

  typedef struct {
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic [2:0] op;
    logic       busy;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_op(rsp_op), .busy(busy)
  );

  // Stand-in for the one-register ALU; force_carry lets a scenario pollute the carry line.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res   <= '0;
      m_carry <= 1'b0;
    end else begin
      case (alu_op)
        3'd0:    {m_carry, m_res} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'd1:    {m_carry, m_res} <= {1'b0, alu_a} - {1'b0, alu_b};
        3'd2:    {m_carry, m_res} <= {1'b0, alu_a & alu_b};
        3'd3:    {m_carry, m_res} <= {1'b0, alu_a | alu_b};
        3'd4:    {m_carry, m_res} <= {1'b0, alu_a ^ alu_b};
        3'd5:    {m_carry, m_res} <= {alu_b, 1'b0};
        3'd6:    {m_carry, m_res} <= {alu_b[0], 1'b0, alu_b[3:1]};
        default: {m_carry, m_res} <= {1'b0, alu_b};
      endcase
    end
  end
  assign alu_result = m_res;
  assign alu_carry  = m_carry | force_carry;

  function automatic rsp_t ref_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    rsp_t r;
    int   ia, ib, s;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    s = ia + ib;
      3'd1:    s = ia - ib;
      3'd2:    s = int'(a & b);
      3'd3:    s = int'(a | b);
      3'd4:    s = int'(a ^ b);
      3'd5:    s = ib * 2;
      3'd6:    s = ib / 2;
      default: s = ib;
    endcase
    r.result = 4'(s);
    r.carry  = (op == 3'd0) ? (s > 15) : (op == 3'd1) ? (s < 0) : 1'b0;
    r.zero   = (r.result == 4'd0);
    r.op     = op;
    r.busy   = 1'b1;
    return r;
  endfunction

  // Inputs only change #1 after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) exp_q.push_back(ref_model(cmd_a, cmd_b, cmd_op));
    if (!rst && rsp_valid && rsp_ready) got_q.push_back('{rsp_result, rsp_carry, rsp_zero, rsp_op, busy});
  end

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int n;
    n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== 11'd0) begin
      n_fail++; $display("FAIL reset_alu: got %h/%h/%b want 0/0/000", alu_a, alu_b, alu_op);
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if ({rsp_result, rsp_carry, rsp_zero, rsp_op} !== 9'd0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got %b %b %b %b want all 0", rsp_result, rsp_carry, rsp_zero, rsp_op);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_add_timing();
    bit ok;
    clear_sb();
    rsp_ready = 1'b1;
    cmd_a = 4'd9; cmd_b = 4'd8; cmd_op = 3'b000; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== {4'd9, 4'd8, 3'b000}) begin
      n_fail++; $display("FAIL add_issue: alu=%h/%h/%b want 9/8/000", alu_a, alu_b, alu_op);
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_rsp_1: rsp_valid=%b want 0", rsp_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_rsp_2: rsp_valid=%b want 0", rsp_valid); end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_op} !== {1'b1, 4'b0001, 1'b1, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL add_rsp: valid=%b res=%b c=%b z=%b op=%b want 1 0001 1 0 000",
               rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_op);
    end
    wait_rsps(1, ok);
    n_checks++;
    if (!ok || got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL add_count: got %0d responses for %0d commands, want 1/1", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_sub();
    bit ok;
    clear_sb();
    rsp_ready = 1'b1;
    push_cmd(4'd5, 4'd5, 3'b001);
    push_cmd(4'd3, 4'd5, 3'b001);
    wait_rsps(2, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL sub_timeout: got %0d responses, want 2", got_q.size());
    end else begin
      n_checks++;
      if ({got_q[0].result, got_q[0].carry, got_q[0].zero, got_q[0].op} !== {4'b0000, 1'b0, 1'b1, 3'b001}) begin
        n_fail++; $display("FAIL sub_zero: got %b c%b z%b want 0000 c0 z1", got_q[0].result, got_q[0].carry, got_q[0].zero);
      end
      n_checks++;
      if ({got_q[1].result, got_q[1].carry, got_q[1].zero, got_q[1].op} !== {4'b1110, 1'b1, 1'b0, 3'b001}) begin
        n_fail++; $display("FAIL sub_borrow: got %b c%b z%b want 1110 c1 z0", got_q[1].result, got_q[1].carry, got_q[1].zero);
      end
    end
  endtask

  task automatic test_logic_carry_mask();
    bit ok;
    logic [3:0] want [3];
    want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b1000;
    clear_sb();
    rsp_ready = 1'b1;
    force_carry = 1'b1;
    push_cmd(4'($urandom), 4'b1001, 3'b101);
    push_cmd(4'($urandom), 4'b1001, 3'b110);
    push_cmd(4'b1100, 4'b1010, 3'b010);
    wait_rsps(3, ok);
    force_carry = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL mask_timeout: got %0d responses, want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({got_q[i].result, got_q[i].carry} !== {want[i], 1'b0}) begin
          n_fail++; $display("FAIL mask_rsp%0d: got %b carry %b want %b carry 0", i, got_q[i].result, got_q[i].carry, want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit acc;
    rsp_t f;
    clear_sb();
    rsp_ready = 1'b0;
    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
    cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) begin cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom); end
    end
    n_checks++;
    if (exp_q.size() != DEPTH + 1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: accepted %0d cmd_ready=%b want %0d and 0", exp_q.size(), cmd_ready, DEPTH + 1);
    end
    cmd_valid = 1'b0;
    f = '{rsp_result, rsp_carry, rsp_zero, rsp_op, 1'b1};
    n_checks++;
    if (exp_q.size() == 0 || rsp_valid !== 1'b1 ||
        {f.result, f.carry, f.zero, f.op} !== {exp_q[0].result, exp_q[0].carry, exp_q[0].zero, exp_q[0].op}) begin
      n_fail++; $display("FAIL bp_first: valid=%b res=%b c=%b z=%b op=%b", rsp_valid, f.result, f.carry, f.zero, f.op);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_op} !== {1'b1, f.result, f.carry, f.zero, f.op}) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: valid=%b res=%b op=%b want 1 %b %b", c, rsp_valid, rsp_result, rsp_op, f.result, f.op);
      end
    end
    rsp_ready = 1'b1;
    wait_rsps(DEPTH + 1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_drain_timeout: got %0d responses, want %0d", got_q.size(), DEPTH + 1);
    end else begin
      for (int i = 0; i < DEPTH + 1; i++) begin
        n_checks++;
        if ({got_q[i].result, got_q[i].carry, got_q[i].zero, got_q[i].op} !==
            {exp_q[i].result, exp_q[i].carry, exp_q[i].zero, exp_q[i].op}) begin
          n_fail++; $display("FAIL bp_order%0d: got %b/%b/%b want %b/%b/%b", i, got_q[i].result, got_q[i].carry, got_q[i].op,
                             exp_q[i].result, exp_q[i].carry, exp_q[i].op);
        end
      end
    end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_recover: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int n;
    clear_sb();
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_cmd(4'($urandom), 4'($urandom), 3'($urandom));
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midop_pre: rsp_valid=%b busy=%b cmd_ready=%b want 0 1 1", rsp_valid, busy, cmd_ready);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midop_async: rsp_valid=%b busy=%b cmd_ready=%b want 0 0 1", rsp_valid, busy, cmd_ready);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    clear_sb();
    rsp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    n_checks++;
    if (got_q.size() != 0 || rsp_valid !== 1'b0 || {alu_a, alu_b, alu_op} !== 11'd0) begin
      n_fail++; $display("FAIL midop_stale: responses=%0d rsp_valid=%b alu=%h/%h/%b want 0 0 0/0/000",
                         got_q.size(), rsp_valid, alu_a, alu_b, alu_op);
    end
    push_cmd(4'($urandom), 4'($urandom), 3'($urandom));
    wait_rsps(1, ok);
    n_checks++;
    if (!ok || exp_q.size() != 1 || got_q.size() != 1 ||
        {got_q[0].result, got_q[0].carry, got_q[0].zero, got_q[0].op} !==
        {exp_q[0].result, exp_q[0].carry, exp_q[0].zero, exp_q[0].op}) begin
      n_fail++; $display("FAIL midop_fresh: ok=%b responses=%0d commands=%0d", ok, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_wrap_random();
    bit ok;
    bit done;
    logic bz;
    done = 1'b0;
    ok = 1'b0;
    bz = 1'bx;
    clear_sb();
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push_cmd(4'($urandom), 4'($urandom), 3'($urandom));
        end
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        wait_rsps(NRAND, ok);
        bz = busy;
        done = 1'b1;
      end
    join
    rsp_ready = 1'b1;
    n_checks++;
    if (!ok || got_q.size() != NRAND || exp_q.size() != NRAND) begin
      n_fail++; $display("FAIL wrap_count: responses=%0d commands=%0d want %0d", got_q.size(), exp_q.size(), NRAND);
    end else begin
      for (int i = 0; i < NRAND; i++) begin
        n_checks++;
        if ({got_q[i].result, got_q[i].carry, got_q[i].zero, got_q[i].op, got_q[i].busy} !==
            {exp_q[i].result, exp_q[i].carry, exp_q[i].zero, exp_q[i].op, 1'b1}) begin
          n_fail++; $display("FAIL wrap_rsp%0d: got %b/%b/%b/%b busy %b want %b/%b/%b/%b busy 1", i,
                             got_q[i].result, got_q[i].carry, got_q[i].zero, got_q[i].op, got_q[i].busy,
                             exp_q[i].result, exp_q[i].carry, exp_q[i].zero, exp_q[i].op);
        end
      end
      n_checks++;
      if (bz !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_end: busy=%b after last handshake, want 0", bz); end
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_sub();
    test_logic_carry_mask();
    test_backpressure();
    test_reset_midop();
    test_wrap_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
